// File: rtl/ultra_echo_capture.sv
// Ultrasonic ranging front end: fires a trigger pulse, times the synchronized echo
// and writes one 25-bit result per measurement into a circular capture RAM.
module ultra_echo_capture #(
    parameter int          TRIG_CYCLES = 10,
    parameter logic [24:0] TIMEOUT     = 25'd1_000_000,
    parameter int          DEPTH       = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        echo_in,
    output logic        trig_out,
    output logic        wr_en,
    output logic [6:0]  wr_add,
    output logic [24:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        wrapped
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, WRITE} state_t;

    localparam logic [24:0] TRIG_LAST = 25'(TRIG_CYCLES - 1);
    localparam logic [24:0] WAIT_LAST = TIMEOUT - 25'd1;
    localparam logic [6:0]  PTR_LAST  = 7'(DEPTH - 1);
    localparam logic [24:0] SAT       = 25'h1FF_FFFF;

    state_t      state_q, state_d;
    logic [24:0] timer_q, timer_d;
    logic [24:0] width_q, width_d;
    logic [6:0]  ptr_q, ptr_d;
    logic        sync1_q, echo_s_q, echo_sd_q;
    logic        trig_q, trig_d, wr_en_q, wr_en_d, busy_q, busy_d;
    logic        done_q, done_d, timeout_q, timeout_d, wrapped_q, wrapped_d;
    logic [6:0]  wr_add_q, wr_add_d;
    logic [24:0] wr_data_q, wr_data_d;
    logic        rise;
    logic        go_write;
    logic [24:0] result;
    logic        armed;

    assign rise = echo_s_q & ~echo_sd_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        width_d   = width_q;
        ptr_d     = ptr_q;
        wr_add_d  = wr_add_q;
        wr_data_d = wr_data_q;
        wrapped_d = wrapped_q;
        go_write  = 1'b0;
        result    = SAT;
        armed     = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = TRIG;
                timer_d = '0;
            end
            TRIG: begin
                timer_d = timer_q + 25'd1;
                if (timer_q == TRIG_LAST) begin
                    state_d = WAIT_RISE;
                    timer_d = '0;
                end
            end
            WAIT_RISE: begin
                timer_d = timer_q + 25'd1;
                if (rise) begin
                    state_d = MEASURE;
                    width_d = 25'd1;
                end else if (timer_q >= WAIT_LAST) begin
                    go_write = 1'b1;
                    armed    = 1'b1;
                end
            end
            MEASURE: begin
                if (!echo_s_q) begin
                    go_write = 1'b1;
                    result   = width_q;
                end else if (width_q >= TIMEOUT) begin
                    // Saturate rather than count past TIMEOUT so the width never wraps.
                    go_write = 1'b1;
                    armed    = 1'b1;
                end else begin
                    width_d = width_q + 25'd1;
                end
            end
            WRITE: begin
                state_d = IDLE;
                ptr_d   = (ptr_q == PTR_LAST) ? 7'd0 : ptr_q + 7'd1;
            end
            default: state_d = IDLE;
        endcase
        // Result fields are latched on entry to WRITE so they line up with wr_en.
        if (go_write) begin
            state_d   = WRITE;
            wr_add_d  = ptr_q;
            wr_data_d = result;
            if (ptr_q == PTR_LAST) wrapped_d = 1'b1;
        end
        wr_en_d   = go_write;
        done_d    = go_write;
        timeout_d = go_write & armed;
        trig_d    = (state_d == TRIG);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            width_q   <= '0;
            ptr_q     <= '0;
            sync1_q   <= 1'b0;
            echo_s_q  <= 1'b0;
            echo_sd_q <= 1'b0;
            trig_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_add_q  <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            width_q   <= width_d;
            ptr_q     <= ptr_d;
            sync1_q   <= echo_in;
            echo_s_q  <= sync1_q;
            echo_sd_q <= echo_s_q;
            trig_q    <= trig_d;
            wr_en_q   <= wr_en_d;
            wr_add_q  <= wr_add_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign trig_out = trig_q;
    assign wr_en    = wr_en_q;
    assign wr_add   = wr_add_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign timeout  = timeout_q;
    assign wrapped  = wrapped_q;
endmodule

// File: tb/tb_ultra_echo_capture.sv
// Directed bench for ultra_echo_capture with a short TIMEOUT so saturation cases stay fast.
module tb_ultra_echo_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        echo_in = 1'b0;
    logic        trig_out, wr_en, busy, done, timeout, wrapped;
    logic [6:0]  wr_add;
    logic [24:0] wr_data;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int trig_cnt = 0;
    int base;

    ultra_echo_capture #(.TRIG_CYCLES(10), .TIMEOUT(25'd200), .DEPTH(100)) dut (
        .clk(clk), .rst(rst), .start(start), .echo_in(echo_in),
        .trig_out(trig_out), .wr_en(wr_en), .wr_add(wr_add), .wr_data(wr_data),
        .busy(busy), .done(done), .timeout(timeout), .wrapped(wrapped)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) wr_cnt++;
        if (trig_out) trig_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // Leaves the bench sitting on the negedge where wr_en is high.
    task automatic wait_wr(input int lim);
        bit found = 0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (wr_en) begin
                found = 1;
                break;
            end
        end
        chk("wr_seen", 32'(found), 32'd1);
    endtask

    task automatic measure(input int h);
        do_start();
        repeat (15) @(negedge clk);
        echo_in = 1'b1;
        repeat (h) @(negedge clk);
        echo_in = 1'b0;
        wait_wr(20);
    endtask

    task automatic chk_write(input string tag, input int add, input logic [24:0] data, input bit to);
        chk({tag, "_add"}, 32'(wr_add), 32'(add));
        chk({tag, "_data"}, 32'(wr_data), 32'(data));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_to"}, 32'(timeout), 32'(to));
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_trig"}, 32'(trig_out), 32'd0);
        chk({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "_wr_add"}, 32'(wr_add), 32'd0);
        chk({tag, "_wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_timeout"}, 32'(timeout), 32'd0);
        chk({tag, "_wrapped"}, 32'(wrapped), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_idle_outs("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Clean 150-cycle echo.
        trig_cnt = 0;
        do_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_trig", 32'(trig_out), 32'd1);
        repeat (15) @(negedge clk);
        chk("t1_trig_len", 32'(trig_cnt), 32'd10);
        echo_in = 1'b1;
        repeat (150) @(negedge clk);
        echo_in = 1'b0;
        wait_wr(20);
        chk_write("t1", 0, 25'd150, 1'b0);
        @(negedge clk);
        chk("t1_wr_pulse", 32'(wr_en), 32'd0);
        chk("t1_busy_low", 32'(busy), 32'd0);
        chk("t1_wr_hold", 32'(wr_data), 32'd150);
        chk("t1_wr_cnt", 32'(wr_cnt), 32'd1);

        // No echo: timeout while waiting for the rise.
        do_start();
        wait_wr(400);
        chk_write("t2", 1, 25'h1FFFFFF, 1'b1);
        @(negedge clk);
        chk("t2_busy_low", 32'(busy), 32'd0);
        chk("t2_to_pulse", 32'(timeout), 32'd0);

        // Echo stuck high: width saturates.
        do_start();
        repeat (15) @(negedge clk);
        echo_in = 1'b1;
        wait_wr(400);
        chk_write("t3", 2, 25'h1FFFFFF, 1'b1);
        echo_in = 1'b0;
        repeat (10) @(negedge clk);
        chk("t3_wr_cnt", 32'(wr_cnt), 32'd3);

        // Early echo and extra starts are ignored; width from the next clean rise.
        base = wr_cnt;
        trig_cnt = 0;
        echo_in = 1'b1;
        do_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        echo_in = 1'b0;
        repeat (6) @(negedge clk);
        echo_in = 1'b1;
        repeat (33) @(negedge clk);
        echo_in = 1'b0;
        wait_wr(20);
        chk_write("t4", 3, 25'd33, 1'b0);
        repeat (12) @(negedge clk);
        chk("t4_single_wr", 32'(wr_cnt - base), 32'd1);
        chk("t4_trig_len", 32'(trig_cnt), 32'd10);
        chk("t4_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of an echo.
        base = wr_cnt;
        do_start();
        repeat (15) @(negedge clk);
        echo_in = 1'b1;
        repeat (20) @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_idle_outs("t5_rst");
        echo_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_no_wr", 32'(wr_cnt - base), 32'd0);
        measure(9);
        chk_write("t5", 0, 25'd9, 1'b0);

        // 101 back-to-back measurements: address wraps, wrapped goes sticky at the 100th.
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 101; i++) begin
            measure(7);
            chk("t6_add", 32'(wr_add), 32'(i % 100));
            chk("t6_data", 32'(wr_data), 32'd7);
            chk("t6_wrapped", 32'(wrapped), (i >= 99) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        chk("t6_wrapped_sticky", 32'(wrapped), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
